// File: rtl/huff_bit_packer.sv
`default_nettype none
// ============================================================================
//  Module   : huff_bit_packer
//  Purpose  : Packs variable-length Huffman code words (MSB-first) into an
//             LSB-first 32-bit word stream with byte count, last flag and flush.
//  Revision : 1.0  initial release
// ============================================================================
module huff_bit_packer #(
    parameter int ACC_W  = 64,
    parameter int CODE_W = 13,
    parameter int OUT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] code_in,
    input  logic [3:0]        code_bits_in,
    input  logic              code_valid_in,
    output logic              code_ready_out,
    input  logic              flush_in,
    output logic [OUT_W-1:0]  word_out,
    output logic              word_valid_out,
    output logic [2:0]        word_bvalid_out,
    output logic              word_last_out,
    input  logic              word_ready_in,
    output logic              flush_done_out
);

    localparam int FILL_W = $clog2(ACC_W + 1);
    localparam int SEL_W  = $clog2(OUT_W);
    localparam logic [FILL_W-1:0] C_OUT_BITS  = FILL_W'(OUT_W);
    localparam logic [FILL_W-1:0] C_READY_MAX = FILL_W'(ACC_W - CODE_W);
    localparam logic [3:0]        C_CODE_MAX  = 4'(CODE_W);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_LAST  = 2'd2
    } state_t;

    state_t              state_q;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [OUT_W-1:0]    word_q;
    logic                wvalid_q;
    logic [2:0]          bvalid_q;
    logic                last_q;
    logic                done_q;

    logic [3:0]          w_nbits;
    logic [CODE_W-1:0]   w_rev_full;
    logic [CODE_W-1:0]   w_rev;
    logic                w_accept;
    logic                w_slot_free;
    logic                w_drain;
    logic                w_final;
    logic [ACC_W-1:0]    w_acc_base;
    logic [FILL_W-1:0]   w_fill_base;
    logic [OUT_W-1:0]    w_tail_mask;
    logic [2:0]          w_tail_bytes;

    assign code_ready_out  = (state_q == S_RUN) && (fill_q <= C_READY_MAX);
    assign word_out        = word_q;
    assign word_valid_out  = wvalid_q;
    assign word_bvalid_out = bvalid_q;
    assign word_last_out   = last_q;
    assign flush_done_out  = done_q;

    assign w_nbits = (code_bits_in > C_CODE_MAX) ? C_CODE_MAX : code_bits_in;

    // Mirror the whole code field, then drop the unused low end so the
    // first-transmitted bit lands at position 0.
    always_comb begin
        w_rev_full = '0;
        for (int i = 0; i < CODE_W; i++) begin
            w_rev_full[i] = code_in[CODE_W-1-i];
        end
    end
    assign w_rev = w_rev_full >> (C_CODE_MAX - w_nbits);

    assign w_accept    = code_valid_in && code_ready_out;
    assign w_slot_free = !wvalid_q || word_ready_in;
    assign w_drain     = (fill_q >= C_OUT_BITS) && w_slot_free;
    assign w_final     = (state_q == S_FLUSH) && (fill_q < C_OUT_BITS) && w_slot_free;

    assign w_acc_base   = w_drain ? (acc_q >> OUT_W) : acc_q;
    assign w_fill_base  = w_drain ? (fill_q - C_OUT_BITS) : fill_q;
    assign w_tail_mask  = ~({OUT_W{1'b1}} << fill_q[SEL_W-1:0]);
    assign w_tail_bytes = 3'((fill_q + FILL_W'(7)) >> 3);

    always_comb begin
        acc_d  = w_acc_base;
        fill_d = w_fill_base;
        if (w_accept) begin
            acc_d  = w_acc_base | ({{(ACC_W-CODE_W){1'b0}}, w_rev} << w_fill_base);
            fill_d = w_fill_base + FILL_W'(w_nbits);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_RUN;
            acc_q    <= '0;
            fill_q   <= '0;
            word_q   <= '0;
            wvalid_q <= 1'b0;
            bvalid_q <= 3'd0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            fill_q <= fill_d;
            done_q <= 1'b0;

            if (w_drain) begin
                word_q   <= acc_q[OUT_W-1:0];
                wvalid_q <= 1'b1;
                bvalid_q <= 3'd4;
                last_q   <= 1'b0;
            end else if (w_final) begin
                word_q   <= acc_q[OUT_W-1:0] & w_tail_mask;
                wvalid_q <= 1'b1;
                bvalid_q <= w_tail_bytes;
                last_q   <= 1'b1;
            end else if (word_ready_in) begin
                wvalid_q <= 1'b0;
                last_q   <= 1'b0;
            end

            case (state_q)
                S_RUN: begin
                    if (flush_in) state_q <= S_FLUSH;
                end
                S_FLUSH: begin
                    if (w_final) state_q <= S_LAST;
                end
                S_LAST: begin
                    // The final word is always pending here, so ready alone completes it.
                    if (word_ready_in) begin
                        state_q <= S_RUN;
                        acc_q   <= '0;
                        fill_q  <= '0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_RUN;
            endcase
        end
    end

endmodule
`default_nettype wire
